regfile_read_arbiter: RTL and testbench

//   Shares one 32:1 register-file read mux (5-bit select, 32-bit data) between NREQ requesters.

---
 rtl/regfile_arb_pkg.sv | 12 +
 rtl/regfile_read_arbiter_rr_pick.sv | 25 ++
 rtl/regfile_read_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_read_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and helpers for the register-file read arbiter
package regfile_arb_pkg;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  localparam int PERF_CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_pick.sv
// rtl/regfile_read_arbiter_rr_pick.sv - combinational round-robin picker
// winner is the first set req bit scanning upward from ptr with wrap-around.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] winner
);

  always_comb begin
    int j;
    j      = 0;
    any    = |req;
    winner = '0;
    // Scan from farthest to nearest so the nearest set bit to ptr is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j[ID_W-1:0]]) winner = j[ID_W-1:0];
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin sharing of one register-file read mux
// Optional per-requester grant counters when RDARB_PERF_CNT_EN is defined.
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int SEL_W = 5,
  parameter  int NREQ  = 4,
  localparam int ID_W  = idx_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*SEL_W-1:0] req_addr,
  output logic [NREQ-1:0]       gnt,
  output logic [SEL_W-1:0]      mux_sel,
  input  logic [WIDTH-1:0]      mux_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [ID_W-1:0]       rsp_id
`ifdef RDARB_PERF_CNT_EN
  ,
  output logic [NREQ*PERF_CNT_W-1:0] grant_cnt
`endif
);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, win_q, pick;
  logic [SEL_W-1:0] sel_q;
  logic             any, load;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (any),
    .winner (pick)
  );

  // Outputs decode from state only, so reset forces them low without waiting for a clock.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    gnt       = '0;
    mux_sel   = '0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          load    = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        gnt[win_q] = 1'b1;
        mux_sel    = sel_q;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        mux_sel   = sel_q;
        if (rsp_ready) begin
          load    = any;
          state_d = any ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      sel_q    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        win_q <= pick;
        sel_q <= req_addr[int'(pick)*SEL_W +: SEL_W];
      end
      if (state_q == READ) begin
        rsp_data <= mux_data;
        rsp_id   <= win_q;
        ptr_q    <= (win_q == ID_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
    end
  end

`ifdef RDARB_PERF_CNT_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    logic [PERF_CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    cnt <= '0;
      else if (gnt[i] && cnt != '1)  cnt <= cnt + 1'b1;
    end
    assign grant_cnt[i*PERF_CNT_W +: PERF_CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - self-checking bench for regfile_read_arbiter
module tb_regfile_read_arbiter;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [19:0] req_addr = '0;
  logic [3:0]  gnt;
  logic [4:0]  mux_sel;
  logic [31:0] mux_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;
`ifdef RDARB_PERF_CNT_EN
  logic [63:0] grant_cnt;
`endif

  logic [31:0] mem [32];
  int n_cmp = 0;
  int n_err = 0;

  assign mux_data = mem[mux_sel];

  always #5 clk = ~clk;

  regfile_read_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef RDARB_PERF_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_addr = '0; rsp_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req = '0; rsp_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (gnt !== 4'b0)     begin n_err++; $display("FAIL reset_gnt got %h want 0", gnt); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    n_cmp++; if (mux_sel !== 5'd0) begin n_err++; $display("FAIL reset_sel got %0d want 0", mux_sel); end
    n_cmp++; if (rsp_data !== 32'd0) begin n_err++; $display("FAIL reset_data got %h want 0", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd0)  begin n_err++; $display("FAIL reset_id got %0d want 0", rsp_id); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    mem[5] = 32'hDEADBEEF;
    req = 4'b0100; req_addr[10 +: 5] = 5'd5; rsp_ready = 1'b1;
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got %b want 0100", gnt); end
    n_cmp++; if (mux_sel !== 5'd5) begin n_err++; $display("FAIL single_sel got %0d want 5", mux_sel); end
    req = '0;
    tick();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data got %h want deadbeef", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL single_id got %0d want 2", rsp_id); end
    n_cmp++; if (gnt !== 4'b0) begin n_err++; $display("FAIL single_gnt_resp got %b want 0", gnt); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || mux_sel !== 5'd0) begin n_err++; $display("FAIL single_idle got v=%b sel=%0d want v=0 sel=0", rsp_valid, mux_sel); end
  endtask

  // Full contention also shows back-to-back service: a gnt every second cycle, no idle gap.
  task automatic test_contention();
    int n_g;
    do_reset();
    n_g = 0;
    req = 4'b1111; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_addr[i*5 +: 5] = 5'($urandom);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c % 2 == 0) begin
        n_cmp++; if (gnt !== 4'(1 << (n_g % NREQ))) begin n_err++; $display("FAIL contention_gnt cycle %0d got %b want %b", c, gnt, 4'(1 << (n_g % NREQ))); end
        n_g++;
      end else begin
        n_cmp++; if (gnt !== 4'b0 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL contention_resp cycle %0d got gnt=%b v=%b want gnt=0 v=1", c, gnt, rsp_valid); end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [4:0] a0;
    logic [31:0] d0;
    do_reset();
    a0 = 5'($urandom);
    req = 4'b0011; req_addr[0 +: 5] = a0; req_addr[5 +: 5] = 5'($urandom); rsp_ready = 1'b0;
    d0 = mem[a0];
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL bp_first_gnt got %b want 0001", gnt); end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== 2'd0 || gnt !== 4'b0) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d got v=%b d=%h id=%0d gnt=%b want v=1 d=%h id=0 gnt=0", c, rsp_valid, rsp_data, rsp_id, gnt, d0);
      end
    end
    rsp_ready = 1'b1;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL bp_next_gnt got %b want 0010", gnt); end
    drain();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0001; req_addr[0 +: 5] = 5'd9; rsp_ready = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0 || rsp_valid !== 1'b0 || mux_sel !== 5'd0) begin n_err++; $display("FAIL async_rst got gnt=%b v=%b sel=%0d want 0 0 0", gnt, rsp_valid, mux_sel); end
    @(negedge clk);
    rst_n = 1'b1; req = 4'b1000; req_addr[15 +: 5] = 5'd17;
    tick();
    n_cmp++; if (gnt !== 4'b1000 || mux_sel !== 5'd17) begin n_err++; $display("FAIL async_first got gnt=%b sel=%0d want 1000 17", gnt, mux_sel); end
    drain();
  endtask

  task automatic test_random();
    int ptr_m, w, w_prev, sel_w;
    bit rsp_out, prev_g, exp_g, p_ready;
    bit pend [4];
    logic [4:0] addr [4];
    logic [3:0] p_req;
    logic [19:0] p_addr;
    logic [31:0] exp_data;
    int exp_id;
    do_reset();
    ptr_m = 0; w = 0; w_prev = 0; sel_w = 0; rsp_out = 0; prev_g = 0;
    exp_data = 0; exp_id = 0;
    for (int i = 0; i < 4; i++) begin pend[i] = 0; addr[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin pend[i] = 1; addr[i] = 5'($urandom); end
        req[i] = pend[i];
        req_addr[i*5 +: 5] = addr[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      p_req = req; p_addr = req_addr; p_ready = rsp_ready;
      tick();
      exp_g = 0;
      if (prev_g) begin
        rsp_out = 1; exp_data = mem[sel_w]; exp_id = w_prev;
      end else if (!rsp_out || p_ready) begin
        rsp_out = 0;
        if (p_req != 4'b0) begin
          for (int k = NREQ - 1; k >= 0; k--)
            if (p_req[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
          exp_g = 1; ptr_m = (w + 1) % NREQ;
          sel_w = int'(p_addr[w*5 +: 5]);
        end
      end
      n_cmp++;
      if (gnt !== (exp_g ? 4'(1 << w) : 4'b0)) begin n_err++; $display("FAIL rand_gnt cycle %0d got %b want %b", c, gnt, exp_g ? 4'(1 << w) : 4'b0); end
      n_cmp++;
      if (mux_sel !== ((exp_g || rsp_out) ? 5'(sel_w) : 5'd0)) begin n_err++; $display("FAIL rand_sel cycle %0d got %0d want %0d", c, mux_sel, (exp_g || rsp_out) ? sel_w : 0); end
      n_cmp++;
      if (rsp_valid !== rsp_out) begin n_err++; $display("FAIL rand_valid cycle %0d got %b want %b", c, rsp_valid, rsp_out); end
      if (rsp_out) begin
        n_cmp++;
        if (rsp_data !== exp_data || rsp_id !== 2'(exp_id)) begin n_err++; $display("FAIL rand_rsp cycle %0d got d=%h id=%0d want d=%h id=%0d", c, rsp_data, rsp_id, exp_data, exp_id); end
      end
      if (exp_g) pend[w] = 0;
      prev_g = exp_g; w_prev = w;
    end
    drain();
  endtask

`ifdef RDARB_PERF_CNT_EN
  task automatic test_perf();
    int n_g;
    do_reset();
    n_g = 0;
    req = 4'b0010; rsp_ready = 1'b1;
    for (int c = 0; c < 30 && n_g < 3; c++) begin
      tick();
      if (gnt[1]) n_g++;
      if (n_g == 3) req = '0;
    end
    drain();
    n_cmp++; if (grant_cnt[16 +: 16] !== 16'd3) begin n_err++; $display("FAIL perf_cnt got %0d want 3", grant_cnt[16 +: 16]); end
    force dut.g_cnt[1].cnt = 16'hFFFF;
    #1;
    release dut.g_cnt[1].cnt;
    req = 4'b0010;
    n_g = 0;
    for (int c = 0; c < 10 && n_g == 0; c++) begin
      tick();
      if (gnt[1]) begin n_g = 1; req = '0; end
    end
    n_cmp++; if (n_g != 1) begin n_err++; $display("FAIL perf_gnt_timeout got %0d grants want 1", n_g); end
    drain();
    n_cmp++; if (grant_cnt[16 +: 16] !== 16'hFFFF) begin n_err++; $display("FAIL perf_sat got %h want ffff", grant_cnt[16 +: 16]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    test_reset();
    test_single_read();
    test_contention();
    test_backpressure();
    test_async_reset();
    test_random();
`ifdef RDARB_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
